// File: rtl/am_uart_pkg.sv
// Shared types and constants for the AM board UART command receiver.
// Holds the byte/parser state encodings, the frame header and the baud divider math.
package am_uart_pkg;

    localparam logic [7:0] CMD_HDR = 8'hA5;

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } byte_state_t;

    typedef enum logic [1:0] {
        WAIT_HDR,
        GET_ADDR,
        GET_DATA,
        GET_SUM
    } parse_state_t;

    // Rounded clocks per oversample tick; never below 1.
    function automatic int unsigned calc_div(input int unsigned clk_freq,
                                             input int unsigned baud,
                                             input int unsigned oversample);
        int unsigned den;
        int unsigned q;
        den = baud * oversample;
        q   = (clk_freq + den / 2) / den;
        return (q == 0) ? 1 : q;
    endfunction

endpackage

// File: rtl/uart_rx_byte.sv
// 8N1 byte receiver: 2-flop synchroniser, oversample tick generator and byte FSM.
// Each data and stop bit is the 2-of-3 majority of the three ticks around mid-bit.
module uart_rx_byte
    import am_uart_pkg::*;
#(
    parameter int unsigned CLK_FREQ   = 50_000_000,
    parameter int unsigned BAUD       = 115200,
    parameter int unsigned OVERSAMPLE = 16
) (
    input  logic       CLK,
    input  logic       RST_n,
    input  logic       uart_rx,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       frame_err
);

    localparam int unsigned DIV    = calc_div(CLK_FREQ, BAUD, OVERSAMPLE);
    localparam int unsigned DIV_W  = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int unsigned TICK_W = $clog2(OVERSAMPLE);

    // r_tick_cnt holds the number of ticks already seen in the bit, so tick N has index N-1.
    localparam logic [DIV_W-1:0]  DIV_LAST   = DIV_W'(DIV - 1);
    localparam logic [TICK_W-1:0] TICK_EARLY = TICK_W'(OVERSAMPLE / 2 - 2);
    localparam logic [TICK_W-1:0] TICK_MID   = TICK_W'(OVERSAMPLE / 2 - 1);
    localparam logic [TICK_W-1:0] TICK_LATE  = TICK_W'(OVERSAMPLE / 2);
    localparam logic [TICK_W-1:0] TICK_LAST  = TICK_W'(OVERSAMPLE - 1);

    logic              r_sync1;
    logic              r_sync2;
    logic              r_rx_prev;
    logic [DIV_W-1:0]  r_div_cnt;
    logic              w_tick;
    logic              w_fall;
    logic              w_div_restart;
    logic              w_maj;

    byte_state_t       r_state;
    byte_state_t       w_state_d;
    logic [TICK_W-1:0] r_tick_cnt;
    logic [TICK_W-1:0] w_tick_cnt_d;
    logic [2:0]        r_bit_idx;
    logic [2:0]        w_bit_idx_d;
    logic [7:0]        r_shift;
    logic [7:0]        w_shift_d;
    logic [1:0]        r_vote;
    logic [1:0]        w_vote_d;
    logic [7:0]        r_rx_data;
    logic [7:0]        w_rx_data_d;
    logic              r_rx_valid;
    logic              w_rx_valid_d;
    logic              r_frame_err;
    logic              w_frame_err_d;

    always_ff @(posedge CLK or negedge RST_n) begin
        if (!RST_n) begin
            r_sync1   <= 1'b1;
            r_sync2   <= 1'b1;
            r_rx_prev <= 1'b1;
        end else begin
            r_sync1   <= uart_rx;
            r_sync2   <= r_sync1;
            r_rx_prev <= r_sync2;
        end
    end

    assign w_fall = r_rx_prev & ~r_sync2;
    assign w_tick = (r_div_cnt == DIV_LAST);
    assign w_maj  = (r_vote[0] & r_vote[1]) | (r_vote[0] & r_sync2) | (r_vote[1] & r_sync2);

    always_ff @(posedge CLK or negedge RST_n) begin
        if (!RST_n) begin
            r_div_cnt <= '0;
        end else if (w_div_restart || w_tick) begin
            r_div_cnt <= '0;
        end else begin
            r_div_cnt <= r_div_cnt + 1'b1;
        end
    end

    always_ff @(posedge CLK or negedge RST_n) begin
        if (!RST_n) begin
            r_state     <= IDLE;
            r_tick_cnt  <= '0;
            r_bit_idx   <= '0;
            r_shift     <= '0;
            r_vote      <= '0;
            r_rx_data   <= '0;
            r_rx_valid  <= 1'b0;
            r_frame_err <= 1'b0;
        end else begin
            r_state     <= w_state_d;
            r_tick_cnt  <= w_tick_cnt_d;
            r_bit_idx   <= w_bit_idx_d;
            r_shift     <= w_shift_d;
            r_vote      <= w_vote_d;
            r_rx_data   <= w_rx_data_d;
            r_rx_valid  <= w_rx_valid_d;
            r_frame_err <= w_frame_err_d;
        end
    end

    always_comb begin
        w_state_d     = r_state;
        w_tick_cnt_d  = r_tick_cnt;
        w_bit_idx_d   = r_bit_idx;
        w_shift_d     = r_shift;
        w_vote_d      = r_vote;
        w_rx_data_d   = r_rx_data;
        w_rx_valid_d  = 1'b0;
        w_frame_err_d = 1'b0;
        w_div_restart = 1'b0;

        case (r_state)
            IDLE: begin
                if (w_fall) begin
                    w_state_d     = START;
                    w_tick_cnt_d  = '0;
                    w_div_restart = 1'b1;
                end
            end
            START: begin
                // Glitch check at mid start bit; data windows begin at the start bit's end.
                if (w_tick) begin
                    w_tick_cnt_d = r_tick_cnt + 1'b1;
                    if (r_tick_cnt == TICK_MID && r_sync2) begin
                        w_state_d = IDLE;
                    end else if (r_tick_cnt == TICK_LAST) begin
                        w_state_d    = DATA;
                        w_tick_cnt_d = '0;
                        w_bit_idx_d  = '0;
                    end
                end
            end
            DATA: begin
                if (w_tick) begin
                    w_tick_cnt_d = r_tick_cnt + 1'b1;
                    if (r_tick_cnt == TICK_EARLY) w_vote_d[0] = r_sync2;
                    if (r_tick_cnt == TICK_MID)   w_vote_d[1] = r_sync2;
                    if (r_tick_cnt == TICK_LATE)  w_shift_d   = {w_maj, r_shift[7:1]};
                    if (r_tick_cnt == TICK_LAST) begin
                        w_tick_cnt_d = '0;
                        if (r_bit_idx == 3'd7) begin
                            w_state_d = STOP;
                        end else begin
                            w_bit_idx_d = r_bit_idx + 1'b1;
                        end
                    end
                end
            end
            STOP: begin
                if (w_tick) begin
                    w_tick_cnt_d = r_tick_cnt + 1'b1;
                    if (r_tick_cnt == TICK_EARLY) w_vote_d[0] = r_sync2;
                    if (r_tick_cnt == TICK_MID)   w_vote_d[1] = r_sync2;
                    // Leaving at mid-stop lets the next start edge arrive right after.
                    if (r_tick_cnt == TICK_LATE) begin
                        w_state_d = IDLE;
                        if (w_maj) begin
                            w_rx_data_d  = r_shift;
                            w_rx_valid_d = 1'b1;
                        end else begin
                            w_frame_err_d = 1'b1;
                        end
                    end
                end
            end
            default: w_state_d = IDLE;
        endcase
    end

    assign rx_data   = r_rx_data;
    assign rx_valid  = r_rx_valid;
    assign frame_err = r_frame_err;

endmodule

// File: rtl/uart_cmd_rx.sv
// UART command receiver: turns A5/ADDR/DATA/SUM frames into single-cycle register writes.
// Bad checksums, framing errors mid-frame and inter-byte timeouts discard the frame.
module uart_cmd_rx
    import am_uart_pkg::*;
#(
    parameter int unsigned CLK_FREQ     = 50_000_000,
    parameter int unsigned BAUD         = 115200,
    parameter int unsigned OVERSAMPLE   = 16,
    parameter int unsigned TIMEOUT_CLKS = 500_000
) (
    input  logic       CLK,
    input  logic       RST_n,
    input  logic       uart_rx,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       frame_err,
    output logic       reg_wr_en,
    output logic [7:0] reg_addr,
    output logic [7:0] reg_wdata,
    output logic       cmd_err
);

    localparam int unsigned     TO_W    = $clog2(TIMEOUT_CLKS + 1);
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CLKS - 1);

    logic [7:0]   w_rx_data;
    logic         w_rx_valid;
    logic         w_frame_err;
    logic         w_timeout;

    parse_state_t r_state;
    parse_state_t w_state_d;
    logic [TO_W-1:0] r_to_cnt;
    logic [TO_W-1:0] w_to_cnt_d;
    logic [7:0]   r_addr_lat;
    logic [7:0]   w_addr_lat_d;
    logic [7:0]   r_data_lat;
    logic [7:0]   w_data_lat_d;
    logic [7:0]   r_reg_addr;
    logic [7:0]   w_reg_addr_d;
    logic [7:0]   r_reg_wdata;
    logic [7:0]   w_reg_wdata_d;
    logic         r_reg_wr_en;
    logic         w_reg_wr_en_d;
    logic         r_cmd_err;
    logic         w_cmd_err_d;

    uart_rx_byte #(
        .CLK_FREQ   (CLK_FREQ),
        .BAUD       (BAUD),
        .OVERSAMPLE (OVERSAMPLE)
    ) u_rx_byte (
        .CLK       (CLK),
        .RST_n     (RST_n),
        .uart_rx   (uart_rx),
        .rx_data   (w_rx_data),
        .rx_valid  (w_rx_valid),
        .frame_err (w_frame_err)
    );

    assign w_timeout = (r_state != WAIT_HDR) && (r_to_cnt == TO_LAST);

    always_ff @(posedge CLK or negedge RST_n) begin
        if (!RST_n) begin
            r_state     <= WAIT_HDR;
            r_to_cnt    <= '0;
            r_addr_lat  <= '0;
            r_data_lat  <= '0;
            r_reg_addr  <= '0;
            r_reg_wdata <= '0;
            r_reg_wr_en <= 1'b0;
            r_cmd_err   <= 1'b0;
        end else begin
            r_state     <= w_state_d;
            r_to_cnt    <= w_to_cnt_d;
            r_addr_lat  <= w_addr_lat_d;
            r_data_lat  <= w_data_lat_d;
            r_reg_addr  <= w_reg_addr_d;
            r_reg_wdata <= w_reg_wdata_d;
            r_reg_wr_en <= w_reg_wr_en_d;
            r_cmd_err   <= w_cmd_err_d;
        end
    end

    always_comb begin
        w_state_d     = r_state;
        w_addr_lat_d  = r_addr_lat;
        w_data_lat_d  = r_data_lat;
        w_reg_addr_d  = r_reg_addr;
        w_reg_wdata_d = r_reg_wdata;
        w_reg_wr_en_d = 1'b0;
        w_cmd_err_d   = 1'b0;

        case (r_state)
            WAIT_HDR: begin
                if (w_rx_valid && (w_rx_data == CMD_HDR)) w_state_d = GET_ADDR;
            end
            GET_ADDR: begin
                if (w_rx_valid) begin
                    w_addr_lat_d = w_rx_data;
                    w_state_d    = GET_DATA;
                end
            end
            GET_DATA: begin
                if (w_rx_valid) begin
                    w_data_lat_d = w_rx_data;
                    w_state_d    = GET_SUM;
                end
            end
            GET_SUM: begin
                if (w_rx_valid) begin
                    w_state_d = WAIT_HDR;
                    if (w_rx_data == (r_addr_lat ^ r_data_lat)) begin
                        w_reg_addr_d  = r_addr_lat;
                        w_reg_wdata_d = r_data_lat;
                        w_reg_wr_en_d = 1'b1;
                    end else begin
                        w_cmd_err_d = 1'b1;
                    end
                end
            end
            default: w_state_d = WAIT_HDR;
        endcase

        if ((r_state != WAIT_HDR) && !w_rx_valid && (w_frame_err || w_timeout)) begin
            w_cmd_err_d = 1'b1;
            w_state_d   = WAIT_HDR;
        end

        // The rx_valid cycle is the first idle clock, so cmd_err lands TIMEOUT_CLKS after it.
        if (w_state_d == WAIT_HDR) begin
            w_to_cnt_d = '0;
        end else if (w_rx_valid) begin
            w_to_cnt_d = TO_W'(1);
        end else begin
            w_to_cnt_d = r_to_cnt + 1'b1;
        end
    end

    assign rx_data   = w_rx_data;
    assign rx_valid  = w_rx_valid;
    assign frame_err = w_frame_err;
    assign reg_wr_en = r_reg_wr_en;
    assign reg_addr  = r_reg_addr;
    assign reg_wdata = r_reg_wdata;
    assign cmd_err   = r_cmd_err;

endmodule

// File: tb/tb_uart_cmd_rx.sv
// Directed bench for uart_cmd_rx, run at a fast baud (4 clocks per tick) and a short timeout.
module tb_uart_cmd_rx;

    localparam int unsigned CLK_FREQ = 50_000_000;
    localparam int unsigned BAUD     = 781_250;
    localparam int unsigned OS       = 16;
    localparam int unsigned TO       = 2000;
    localparam int          BIT_CLKS = 64;

    logic       CLK = 1'b0;
    logic       RST_n = 1'b0;
    logic       uart_rx = 1'b1;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       frame_err;
    logic       reg_wr_en;
    logic [7:0] reg_addr;
    logic [7:0] reg_wdata;
    logic       cmd_err;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int n_valid = 0, n_ferr = 0, n_wr = 0, n_cmd = 0;
    int t_valid = 0, t_ferr = 0, t_wr = 0, t_cmd = 0;

    uart_cmd_rx #(
        .CLK_FREQ     (CLK_FREQ),
        .BAUD         (BAUD),
        .OVERSAMPLE   (OS),
        .TIMEOUT_CLKS (TO)
    ) dut (
        .CLK       (CLK),
        .RST_n     (RST_n),
        .uart_rx   (uart_rx),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .frame_err (frame_err),
        .reg_wr_en (reg_wr_en),
        .reg_addr  (reg_addr),
        .reg_wdata (reg_wdata),
        .cmd_err   (cmd_err)
    );

    always #5 CLK = ~CLK;

    always @(posedge CLK) cyc <= cyc + 1;

    always @(negedge CLK) begin
        if (rx_valid)  begin n_valid++; t_valid = cyc; end
        if (frame_err) begin n_ferr++;  t_ferr  = cyc; end
        if (reg_wr_en) begin n_wr++;    t_wr    = cyc; end
        if (cmd_err)   begin n_cmd++;   t_cmd   = cyc; end
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    task automatic idle(input int n);
        uart_rx = 1'b1;
        repeat (n) @(negedge CLK);
    endtask

    task automatic send_byte(input logic [7:0] d, input logic stop);
        uart_rx = 1'b0;
        repeat (BIT_CLKS) @(negedge CLK);
        for (int i = 0; i < 8; i++) begin
            uart_rx = d[i];
            repeat (BIT_CLKS) @(negedge CLK);
        end
        uart_rx = stop;
        repeat (BIT_CLKS) @(negedge CLK);
        uart_rx = 1'b1;
    endtask

    // One tick-wide inversion centred on the middle sample of data bit fb.
    task automatic send_flip(input logic [7:0] d, input int fb);
        uart_rx = 1'b0;
        repeat (BIT_CLKS) @(negedge CLK);
        for (int i = 0; i < 8; i++) begin
            uart_rx = d[i];
            if (i == fb) begin
                repeat (30) @(negedge CLK);
                uart_rx = ~d[i];
                repeat (4) @(negedge CLK);
                uart_rx = d[i];
                repeat (30) @(negedge CLK);
            end else begin
                repeat (BIT_CLKS) @(negedge CLK);
            end
        end
        uart_rx = 1'b1;
        repeat (BIT_CLKS) @(negedge CLK);
    endtask

    task automatic send_frame(input logic [7:0] a, input logic [7:0] b,
                              input logic [7:0] c, input logic [7:0] d);
        send_byte(a, 1'b1);
        send_byte(b, 1'b1);
        send_byte(c, 1'b1);
        send_byte(d, 1'b1);
    endtask

    task automatic test_reset;
        @(negedge CLK);
        checks++; if (rx_data !== 8'h00) begin errors++; $display("FAIL reset_rx_data: got %h want 00", rx_data); end
        checks++; if (reg_addr !== 8'h00) begin errors++; $display("FAIL reset_reg_addr: got %h want 00", reg_addr); end
        checks++; if (reg_wdata !== 8'h00) begin errors++; $display("FAIL reset_reg_wdata: got %h want 00", reg_wdata); end
        checks++; if ({rx_valid, frame_err, reg_wr_en, cmd_err} !== 4'b0000) begin
            errors++; $display("FAIL reset_pulses: got %b want 0000", {rx_valid, frame_err, reg_wr_en, cmd_err});
        end
        RST_n = 1'b1;
        idle(20);
    endtask

    task automatic test_single_byte;
        int bv, bf, c0;
        bv = n_valid; bf = n_ferr; c0 = cyc;
        send_byte(8'h3C, 1'b1);
        idle(10);
        checks++; if (n_valid - bv != 1) begin errors++; $display("FAIL single_valid_count: got %0d want 1", n_valid - bv); end
        checks++; if (rx_data !== 8'h3C) begin errors++; $display("FAIL single_data: got %h want 3c", rx_data); end
        checks++; if (n_ferr != bf) begin errors++; $display("FAIL single_no_ferr: got %0d want 0", n_ferr - bf); end
        // Mid-stop is 9.5 bits (608 clocks) after the start edge, plus a few sync/register clocks.
        checks++; if (t_valid - c0 < 600 || t_valid - c0 > 630) begin
            errors++; $display("FAIL single_latency: got %0d want 600..630", t_valid - c0);
        end
    endtask

    task automatic test_back_to_back;
        int bw, bc, bv;
        bw = n_wr; bc = n_cmd; bv = n_valid;
        send_frame(8'hA5, 8'h10, 8'h5A, 8'h4A);
        idle(20);
        checks++; if (n_valid - bv != 4) begin errors++; $display("FAIL b2b_valid_count: got %0d want 4", n_valid - bv); end
        checks++; if (n_wr - bw != 1) begin errors++; $display("FAIL b2b_wr_count: got %0d want 1", n_wr - bw); end
        checks++; if (reg_addr !== 8'h10) begin errors++; $display("FAIL b2b_addr: got %h want 10", reg_addr); end
        checks++; if (reg_wdata !== 8'h5A) begin errors++; $display("FAIL b2b_wdata: got %h want 5a", reg_wdata); end
        checks++; if (t_wr - t_valid != 1) begin errors++; $display("FAIL b2b_wr_latency: got %0d want 1", t_wr - t_valid); end
        checks++; if (n_cmd != bc) begin errors++; $display("FAIL b2b_no_cmd_err: got %0d want 0", n_cmd - bc); end
    endtask

    task automatic test_bad_sum;
        int bw, bc;
        bw = n_wr; bc = n_cmd;
        send_frame(8'hA5, 8'h10, 8'h5A, 8'h00);
        idle(20);
        checks++; if (n_cmd - bc != 1) begin errors++; $display("FAIL badsum_cmd_err: got %0d want 1", n_cmd - bc); end
        checks++; if (n_wr != bw) begin errors++; $display("FAIL badsum_no_wr: got %0d want 0", n_wr - bw); end
        checks++; if (t_cmd - t_valid != 1) begin errors++; $display("FAIL badsum_latency: got %0d want 1", t_cmd - t_valid); end
        checks++; if (reg_addr !== 8'h10) begin errors++; $display("FAIL badsum_addr_held: got %h want 10", reg_addr); end
        bw = n_wr;
        send_frame(8'hA5, 8'h22, 8'h33, 8'h11);
        idle(20);
        checks++; if (n_wr - bw != 1) begin errors++; $display("FAIL badsum_recover_wr: got %0d want 1", n_wr - bw); end
        checks++; if ({reg_addr, reg_wdata} !== 16'h2233) begin
            errors++; $display("FAIL badsum_recover_regs: got %h want 2233", {reg_addr, reg_wdata});
        end
    endtask

    task automatic test_hdr_payload;
        int bw;
        bw = n_wr;
        send_frame(8'hA5, 8'hA5, 8'h07, 8'hA2);
        idle(20);
        checks++; if (n_wr - bw != 1) begin errors++; $display("FAIL hdrpay_wr: got %0d want 1", n_wr - bw); end
        checks++; if ({reg_addr, reg_wdata} !== 16'hA507) begin
            errors++; $display("FAIL hdrpay_regs: got %h want a507", {reg_addr, reg_wdata});
        end
    endtask

    task automatic test_frame_err;
        int bv, bf, bc, bw;
        bv = n_valid; bf = n_ferr; bc = n_cmd;
        send_byte(8'hA5, 1'b1);
        send_byte(8'h10, 1'b1);
        send_byte(8'h55, 1'b0);
        idle(BIT_CLKS);
        checks++; if (n_ferr - bf != 1) begin errors++; $display("FAIL ferr_pulse: got %0d want 1", n_ferr - bf); end
        checks++; if (n_cmd - bc != 1) begin errors++; $display("FAIL ferr_cmd_err: got %0d want 1", n_cmd - bc); end
        checks++; if (t_cmd - t_ferr != 1) begin errors++; $display("FAIL ferr_cmd_latency: got %0d want 1", t_cmd - t_ferr); end
        checks++; if (n_valid - bv != 2) begin errors++; $display("FAIL ferr_valid_count: got %0d want 2", n_valid - bv); end
        checks++; if (rx_data !== 8'h10) begin errors++; $display("FAIL ferr_data_kept: got %h want 10", rx_data); end
        // Headerless bytes must be ignored if the parser really returned to WAIT_HDR.
        bw = n_wr; bc = n_cmd; bf = n_ferr;
        send_byte(8'h12, 1'b1);
        send_byte(8'h34, 1'b1);
        send_byte(8'h26, 1'b1);
        send_byte(8'h77, 1'b0);
        idle(BIT_CLKS);
        checks++; if (n_cmd != bc) begin errors++; $display("FAIL ferr_idle_no_cmd_err: got %0d want 0", n_cmd - bc); end
        checks++; if (n_wr != bw) begin errors++; $display("FAIL ferr_idle_no_wr: got %0d want 0", n_wr - bw); end
        checks++; if (n_ferr - bf != 1) begin errors++; $display("FAIL ferr_idle_pulse: got %0d want 1", n_ferr - bf); end
    endtask

    task automatic test_glitch_vote;
        int bv, bf;
        bv = n_valid; bf = n_ferr;
        uart_rx = 1'b0;
        repeat (3) @(negedge CLK);
        idle(700);
        checks++; if (n_valid != bv || n_ferr != bf) begin
            errors++; $display("FAIL glitch_no_pulse: got valid %0d ferr %0d want 0 0", n_valid - bv, n_ferr - bf);
        end
        send_flip(8'hC3, 2);
        idle(10);
        checks++; if (n_valid - bv != 1) begin errors++; $display("FAIL vote0_valid: got %0d want 1", n_valid - bv); end
        checks++; if (rx_data !== 8'hC3) begin errors++; $display("FAIL vote0_data: got %h want c3", rx_data); end
        send_flip(8'h81, 0);
        idle(10);
        checks++; if (rx_data !== 8'h81) begin errors++; $display("FAIL vote1_data: got %h want 81", rx_data); end
    endtask

    task automatic test_timeout;
        int bc, bw, waited;
        bc = n_cmd; bw = n_wr;
        send_byte(8'hA5, 1'b1);
        send_byte(8'h10, 1'b1);
        waited = 0;
        while (n_cmd == bc && waited < 3000) begin
            @(negedge CLK);
            waited++;
        end
        idle(2);
        checks++; if (n_cmd - bc != 1) begin errors++; $display("FAIL timeout_fire: got %0d want 1", n_cmd - bc); end
        checks++; if (t_cmd - t_valid != TO) begin
            errors++; $display("FAIL timeout_latency: got %0d want %0d", t_cmd - t_valid, TO);
        end
        send_frame(8'hA5, 8'h44, 8'h55, 8'h11);
        idle(20);
        checks++; if (n_wr - bw != 1) begin errors++; $display("FAIL timeout_recover_wr: got %0d want 1", n_wr - bw); end
        checks++; if ({reg_addr, reg_wdata} !== 16'h4455) begin
            errors++; $display("FAIL timeout_recover_regs: got %h want 4455", {reg_addr, reg_wdata});
        end
        bc = n_cmd;
        idle(2500);
        checks++; if (n_cmd != bc) begin errors++; $display("FAIL timeout_idle_quiet: got %0d want 0", n_cmd - bc); end
    endtask

    task automatic test_reset_mid;
        int bv, bf;
        uart_rx = 1'b0;
        repeat (BIT_CLKS + 32) @(negedge CLK);
        RST_n = 1'b0;
        #1;
        checks++; if ({rx_data, reg_addr, reg_wdata} !== 24'h000000) begin
            errors++; $display("FAIL rstmid_regs: got %h want 000000", {rx_data, reg_addr, reg_wdata});
        end
        checks++; if ({rx_valid, frame_err, reg_wr_en, cmd_err} !== 4'b0000) begin
            errors++; $display("FAIL rstmid_pulses: got %b want 0000", {rx_valid, frame_err, reg_wr_en, cmd_err});
        end
        @(negedge CLK);
        uart_rx = 1'b1;
        repeat (5) @(negedge CLK);
        RST_n = 1'b1;
        bv = n_valid; bf = n_ferr;
        idle(700);
        checks++; if (n_valid != bv || n_ferr != bf) begin
            errors++; $display("FAIL rstmid_quiet: got valid %0d ferr %0d want 0 0", n_valid - bv, n_ferr - bf);
        end
        send_byte(8'h96, 1'b1);
        idle(10);
        checks++; if (n_valid - bv != 1) begin errors++; $display("FAIL rstmid_next_valid: got %0d want 1", n_valid - bv); end
        checks++; if (rx_data !== 8'h96) begin errors++; $display("FAIL rstmid_next_data: got %h want 96", rx_data); end
    endtask

    initial begin
        test_reset();
        test_single_byte();
        test_back_to_back();
        test_bad_sum();
        test_hdr_payload();
        test_frame_err();
        test_glitch_vote();
        test_timeout();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
